vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_pix_tick.sv | 28 ++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, total derivation and the 10-bit coordinate type.
// Default values describe 640x480 at 60 Hz with a 25 MHz pixel rate.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    // Converts an integer boundary to the 10-bit compare domain.
    function automatic coord_t to_coord(input int value);
        return coord_t'(value);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable. With VGA_PIXDIV2_EN defined the 50 MHz clk is halved;
// otherwise clk is already the pixel clock and the tick is high whenever reset is low.
module vga_pix_tick (
`ifdef VGA_PIXDIV2_EN
    input  logic clk,
`endif
    input  logic reset,
    output logic tick
);

`ifdef VGA_PIXDIV2_EN
    logic div_q;

    // Cleared in reset, so the first high phase lands on the second clk after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign tick = div_q;
`else
    assign tick = ~reset;
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered sync/blank/frame decode.
// Optional build macro VGA_PIXDIV2_EN selects a 50 MHz clk divided by two.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] HCounter,
    output logic [9:0] VCounter,
    output logic       hSync,
    output logic       vSync,
    output logic       videoOn,
    output logic       pixTick,
    output logic       frameStart
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST   = to_coord(H_TOTAL - 1);
    localparam coord_t V_LAST   = to_coord(V_TOTAL - 1);
    localparam coord_t H_VIS    = to_coord(H_VISIBLE);
    localparam coord_t V_VIS    = to_coord(V_VISIBLE);
    localparam coord_t HS_START = to_coord(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = to_coord(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = to_coord(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = to_coord(V_VISIBLE + V_FRONT + V_SYNC);

    coord_t h_q;
    coord_t v_q;
    coord_t h_next;
    coord_t v_next;
    logic   hsync_q;
    logic   vsync_q;
    logic   video_q;
    logic   frame_q;
    logic   tick;

    vga_pix_tick u_pix_tick (
`ifdef VGA_PIXDIV2_EN
        .clk   (clk),
`endif
        .reset (reset),
        .tick  (tick)
    );

    // Position the counters move to on the next tick; >= keeps them in range
    // even if a parameter change ever leaves a stale value above the last index.
    always_comb begin
        h_next = h_q + coord_t'(1);
        v_next = v_q;
        if (h_q >= H_LAST) begin
            h_next = '0;
            if (v_q >= V_LAST) begin
                v_next = '0;
            end else begin
                v_next = v_q + coord_t'(1);
            end
        end
    end

    // Decode from the next position so flags and counters change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            frame_q <= 1'b0;
        end else if (tick) begin
            h_q     <= h_next;
            v_q     <= v_next;
            hsync_q <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync_q <= !((v_next >= VS_START) && (v_next < VS_END));
            video_q <= (h_next < H_VIS) && (v_next < V_VIS);
            frame_q <= (h_next == '0) && (v_next == '0);
        end
    end

    assign HCounter   = h_q;
    assign VCounter   = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign videoOn    = video_q;
    assign frameStart = frame_q;
    assign pixTick    = tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-size instance checked by a vector table and
// hand sequences, reduced-size instance checked against a linear-pixel-index model.
module tb_vga_timing_gen;

`ifdef VGA_PIXDIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Reduced raster for whole-frame checks.
    localparam int B_HV = 16, B_HF = 2, B_HS = 3, B_HB = 4;
    localparam int B_VV = 10, B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_HT  = B_HV + B_HF + B_HS + B_HB;
    localparam int B_VT  = B_VV + B_VF + B_VS + B_VB;
    localparam int B_TOT = B_HT * B_VT;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [9:0] HCounter_a, VCounter_a, HCounter_b, VCounter_b;
    logic hSync_a, vSync_a, videoOn_a, pixTick_a, frameStart_a;
    logic hSync_b, vSync_b, videoOn_b, pixTick_b, frameStart_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .HCounter   (HCounter_a),
        .VCounter   (VCounter_a),
        .hSync      (hSync_a),
        .vSync      (vSync_a),
        .videoOn    (videoOn_a),
        .pixTick    (pixTick_a),
        .frameStart (frameStart_a)
    );

    vga_timing_gen #(
        .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB)
    ) dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .HCounter   (HCounter_b),
        .VCounter   (VCounter_b),
        .hSync      (hSync_b),
        .vSync      (vSync_b),
        .videoOn    (videoOn_b),
        .pixTick    (pixTick_b),
        .frameStart (frameStart_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- instance A: table and hand sequences ----------------
    typedef struct {
        int         pos;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       fs;
    } vec_t;

    vec_t tbl[11];

    int  hs_cnt   = 0;
    int  hs_first = -1;
    logic cnt_en_a = 1'b0;

    always @(negedge clk) begin
        if (cnt_en_a && !rst_a && VCounter_a == 10'd0 && pixTick_a && !hSync_a) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(HCounter_a);
        end
    end

    task automatic step_a(input int edges);
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_a(input string tag, input vec_t e);
        chk({tag, "_h"}, HCounter_a, e.h);
        chk({tag, "_v"}, VCounter_a, e.v);
        chk({tag, "_hsync"}, hSync_a, e.hs);
        chk({tag, "_vsync"}, vSync_a, e.vs);
        chk({tag, "_video"}, videoOn_a, e.vid);
        chk({tag, "_frame"}, frameStart_a, e.fs);
        // Samples sit right after an advance, where the divided tick is low.
        chk({tag, "_tick"}, pixTick_a, (DIV == 1) ? 1 : 0);
    endtask

    task automatic run_a();
        vec_t e;
        tbl[0]  = '{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{640, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{655, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{656, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{751, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{752, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{799, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{801, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_reset_h", HCounter_a, 0);
        chk("a_reset_video", videoOn_a, 0);
        chk("a_reset_tick", pixTick_a, 0);
        #2 rst_a = 1'b0;
        cnt_en_a = 1'b1;
        #1 check_a("a_t0", tbl[0]);
        for (int i = 1; i < 11; i++) begin
            step_a(DIV * (tbl[i].pos - tbl[i-1].pos));
            check_a($sformatf("a_t%0d", i), tbl[i]);
        end
        cnt_en_a = 1'b0;
        chk("a_hsync_width", hs_cnt, 96);
        chk("a_hsync_first", hs_first, 656);

        // Mid-line reset between edges, then resume from (0,0).
        step_a(DIV * (1100 - 801));
        chk("a_pre_rst_h", HCounter_a, 300);
        chk("a_pre_rst_v", VCounter_a, 1);
        #2 rst_a = 1'b1;
        #1;
        e = '{0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        chk("a_async_h", HCounter_a, 0);
        chk("a_async_v", VCounter_a, 0);
        chk("a_async_video", videoOn_a, 0);
        chk("a_async_hsync", hSync_a, 1);
        chk("a_async_tick", pixTick_a, 0);
        @(negedge clk);
        #2 rst_a = 1'b0;
        #1 check_a("a_resume0", e);
        step_a(DIV);
        e = '{1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        check_a("a_resume1", e);
    endtask

    // ---------------- instance B: reference model ----------------
    initial begin : model_b
        int   pos, h, v;
        bit   fresh, div, etick;
        logic e_hs, e_vs, e_vid, e_fs, e_tick;
        logic [9:0] e_h, e_v;
        pos = 0; fresh = 1'b1; div = 1'b0;
        forever begin
            @(negedge clk);
            h = pos % B_HT;
            v = pos / B_HT;
            if (rst_b) begin
                e_h = 10'd0; e_v = 10'd0; e_hs = 1'b1; e_vs = 1'b1;
                e_vid = 1'b0; e_fs = 1'b0; e_tick = 1'b0;
            end else begin
                e_h    = 10'(h);
                e_v    = 10'(v);
                e_hs   = !(h >= B_HV + B_HF && h < B_HV + B_HF + B_HS);
                e_vs   = !(v >= B_VV + B_VF && v < B_VV + B_VF + B_VS);
                e_vid  = !fresh && h < B_HV && v < B_VV;
                e_fs   = !fresh && pos == 0;
                e_tick = (DIV == 2) ? div : 1'b1;
            end
            chk("b_h", HCounter_b, e_h);
            chk("b_v", VCounter_b, e_v);
            chk("b_hsync", hSync_b, e_hs);
            chk("b_vsync", vSync_b, e_vs);
            chk("b_video", videoOn_b, e_vid);
            chk("b_frame", frameStart_b, e_fs);
            chk("b_tick", pixTick_b, e_tick);
            @(posedge clk);
            if (rst_b) begin
                pos = 0; fresh = 1'b1; div = 1'b0;
            end else begin
                etick = (DIV == 2) ? div : 1'b1;
                if (etick) begin
                    pos   = (pos + 1) % B_TOT;
                    fresh = 1'b0;
                end
                div = !div;
            end
        end
    end

    task automatic run_b();
        int   rises, ticks, vid, hold;
        logic prev_fs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_b = 1'b0;

        // Whole-frame tick and visible-pixel counts between frameStart pulses.
        rises = 0; ticks = 0; vid = 0; prev_fs = 1'b0;
        for (int c = 0; c < DIV * B_TOT * 3 + 20 && rises < 3; c++) begin
            @(negedge clk);
            if (frameStart_b && !prev_fs) begin
                if (rises > 0) begin
                    chk("b_frame_ticks", ticks, B_TOT);
                    chk("b_frame_video", vid, B_HV * B_VV);
                end
                rises++;
                ticks = 0;
                vid   = 0;
            end
            prev_fs = frameStart_b;
            if (pixTick_b) begin
                ticks++;
                if (videoOn_b) vid++;
            end
        end
        chk("b_frame_pulses", rises, 3);

        // Random asynchronous resets at arbitrary raster positions.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 600)) @(negedge clk);
            #2 rst_b = 1'b1;
            #1;
            chk("b_async_h", HCounter_b, 0);
            chk("b_async_v", VCounter_b, 0);
            chk("b_async_vsync", vSync_b, 1);
            chk("b_async_frame", frameStart_b, 0);
            chk("b_async_tick", pixTick_b, 0);
            hold = $urandom_range(1, 3);
            repeat (hold) @(negedge clk);
            #2 rst_b = 1'b0;
        end
        repeat (DIV * B_TOT + 5) @(negedge clk);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: run did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
